cz_flag_unit: RTL
=================

# cz_flag_unit

Consumer end of the ALU result/flag interface: the EX/MEM pipeline boundary that captures the ALU's 16-bit result, zero and carry, and holds the architectural C and Z flag registers. It evaluates each instruction's CZ condition field (ADD/ADC/ADZ, NDU/NDC/NDZ style), converting a failed condition into a no-write bubble. It tracks a load whose Z flag resolves one stage later and holds dependent Z-conditional instructions until it does.

## Interface
Parameters:
- DW, 16, datapath width
- RW, 3, register-address width

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  EX stage presents an instruction
- cond  in  2  00 unconditional, 10 execute if C, 01 execute if Z, 11 reserved
- set_c  in  1  instruction writes C when executed
- set_z  in  1  instruction writes Z when executed
- is_load  in  1  Z for this instruction is produced later via mem_z
- alu_out  in  DW  ALU result
- alu_zero  in  1  ALU zero flag
- alu_carry  in  1  ALU carry flag (already 0 for NAND ops)
- rd  in  RW  destination register
- wr_en_in  in  1  instruction writes rd
- stall  in  1  downstream stall; freeze capture register
- flush  in  1  squash the EX-stage instruction
- mem_z_valid  in  1  late Z for the pending load is available
- mem_z  in  1  late Z value
- out_valid  out  1  output register holds an instruction
- out_data  out  DW  registered alu_out
- out_rd  out  RW  registered rd
- out_wr_en  out  1  wr_en_in AND condition met
- exec_taken  out  1  condition met for the registered instruction
- c_flag  out  1  architectural C
- z_flag  out  1  architectural Z
- hold_req  out  1  combinational: EX instruction must not advance this cycle
- illegal  out  1  registered: cond==11 captured

## Operation
- Priority per edge: rst > flush > stall > capture.
- rst: every output register, c_flag, z_flag, illegal cleared to 0; state IDLE.
- Condition met: cond 00 always; 10 iff c_flag; 01 iff z_flag; 11 never (illegal=1).
- hold_req = in_valid & cond==01 & state==ZPEND & ~flush. Held instruction is not captured; out_valid drops to 0 next edge (bubble).
- Capture (in_valid, no hold, no stall, no flush): out_* loaded; out_valid=1; exec_taken=met; out_wr_en=wr_en_in&met. If met: set_c → c_flag<=alu_carry; set_z&~is_load → z_flag<=alu_zero; set_z&is_load → state ZPEND.
- Failed condition: instruction still occupies the slot (out_valid=1), no flag change, no write.
- flush: out_valid<=0 and out_wr_en<=0, flags untouched; does not cancel an existing ZPEND (the load is older).
- stall: all out_* and captured flags hold; hold_req still computed.
- States: IDLE → ZPEND on captured executing load with set_z. ZPEND → IDLE on mem_z_valid (z_flag<=mem_z), or on capture of a newer executing non-load set_z instruction (its alu_zero wins; subsequent mem_z_valid ignored). ZPEND → ZPEND on newer executing load.
- mem_z_valid in IDLE: ignored. Resolution proceeds during stall.
- Simultaneous mem_z_valid and capture of a newer set_z: newer value wins.

## Timing
- Latency 1 cycle in → out; flags visible the cycle after capture.
- Back-to-back dependent C/Z-conditional: no stall.
- ZPEND + cond 01: hold_req high until the cycle after mem_z_valid (no same-cycle bypass).

## Structure
- Shared package: CZ condition encodings (COND_ALWAYS, COND_C, COND_Z, COND_RSVD), state enum (IDLE, ZPEND).
- One sub-module: cz_cond_eval (cond, c_flag, z_flag → met, illegal), combinational.

## Test plan
- Reset mid-ZPEND with out_valid=1 → next cycle all outputs 0, state IDLE, hold_req 0.
- ADD 0xFFFF+0x0001 (alu_out=0, zero=1, carry=1, cond 00, set_c/z) then ADC → out_wr_en=1 for both, c_flag=1, z_flag=1.
- c_flag=0, ADC with wr_en_in=1 → out_valid=1, out_wr_en=0, exec_taken=0, flags unchanged.
- Load (set_z, is_load) then ADZ next cycle → hold_req=1 one cycle; mem_z_valid=1, mem_z=1 → ADZ captured next, out_wr_en=1.
- ZPEND, then ADD with alu_zero=0 captured same cycle as mem_z_valid, mem_z=1 → z_flag=0, IDLE.
- cond=11 → illegal=1, out_wr_en=0; flush with in_valid → out_valid=0, flags unchanged.

Source files
------------

// File: rtl/cz_flag_unit_pkg.sv
// Shared definitions for the CZ flag unit: condition-field encodings and the
// late-Z tracking state.
package cz_flag_unit_pkg;

   // CZ condition field of an instruction
   localparam logic [1:0] COND_ALWAYS = 2'b00;
   localparam logic [1:0] COND_Z      = 2'b01;
   localparam logic [1:0] COND_C      = 2'b10;
   localparam logic [1:0] COND_RSVD   = 2'b11;

   // IDLE: z_flag is up to date. ZPEND: an older load still owes its Z value.
   typedef enum logic [0:0] {
      IDLE  = 1'b0,
      ZPEND = 1'b1
   } cz_state_e;

endpackage

// File: rtl/cz_cond_eval.sv
// Combinational evaluation of an instruction's CZ condition field against the
// architectural flags.
module cz_cond_eval
   import cz_flag_unit_pkg::*;
(
   input  logic [1:0] cond,
   input  logic       c_flag,
   input  logic       z_flag,
   output logic       met,
   output logic       illegal
);

   // Decode the condition; the reserved encoding never executes
   always_comb begin
      met     = 1'b0;
      illegal = 1'b0;
      unique case (cond)
         COND_ALWAYS: met = 1'b1;
         COND_C:      met = c_flag;
         COND_Z:      met = z_flag;
         COND_RSVD:   illegal = 1'b1;
         default:     met = 1'b0;
      endcase
   end

endmodule

// File: rtl/cz_flag_unit.sv
// EX/MEM boundary register with architectural C/Z flags. Failed conditions
// become no-write slots; Z-conditional instructions are held while a load's
// Z value is still outstanding.
module cz_flag_unit
   import cz_flag_unit_pkg::*;
#(
   parameter int unsigned DW = 16,
   parameter int unsigned RW = 3
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          in_valid,
   input  logic [1:0]    cond,
   input  logic          set_c,
   input  logic          set_z,
   input  logic          is_load,
   input  logic [DW-1:0] alu_out,
   input  logic          alu_zero,
   input  logic          alu_carry,
   input  logic [RW-1:0] rd,
   input  logic          wr_en_in,
   input  logic          stall,
   input  logic          flush,
   input  logic          mem_z_valid,
   input  logic          mem_z,
   output logic          out_valid,
   output logic [DW-1:0] out_data,
   output logic [RW-1:0] out_rd,
   output logic          out_wr_en,
   output logic          exec_taken,
   output logic          c_flag,
   output logic          z_flag,
   output logic          hold_req,
   output logic          illegal
);

   cz_state_e     state_q, state_d;
   logic          out_valid_q, out_valid_d;
   logic [DW-1:0] out_data_q, out_data_d;
   logic [RW-1:0] out_rd_q, out_rd_d;
   logic          out_wr_en_q, out_wr_en_d;
   logic          exec_taken_q, exec_taken_d;
   logic          illegal_q, illegal_d;
   logic          c_flag_q, c_flag_d;
   logic          z_flag_q, z_flag_d;

   logic          met;
   logic          cond_illegal;
   logic          capture;
   logic          exec_cap;

   cz_cond_eval u_cond_eval (
      .cond    (cond),
      .c_flag  (c_flag_q),
      .z_flag  (z_flag_q),
      .met     (met),
      .illegal (cond_illegal)
   );

   // Hold a Z-conditional instruction while the load's Z is unresolved
   always_comb begin
      hold_req = in_valid & (cond == COND_Z) & (state_q == ZPEND) & ~flush;
      capture  = in_valid & ~hold_req & ~stall & ~flush;
      exec_cap = capture & met;
   end

   // Output-slot next state: flush > stall > capture > bubble
   always_comb begin
      out_valid_d  = out_valid_q;
      out_data_d   = out_data_q;
      out_rd_d     = out_rd_q;
      out_wr_en_d  = out_wr_en_q;
      exec_taken_d = exec_taken_q;
      illegal_d    = illegal_q;
      if (flush) begin
         out_valid_d  = 1'b0;
         out_wr_en_d  = 1'b0;
         exec_taken_d = 1'b0;
         illegal_d    = 1'b0;
      end else if (stall) begin
         // freeze the slot
      end else if (capture) begin
         out_valid_d  = 1'b1;
         out_data_d   = alu_out;
         out_rd_d     = rd;
         out_wr_en_d  = wr_en_in & met;
         exec_taken_d = met;
         illegal_d    = cond_illegal;
      end else begin
         out_valid_d  = 1'b0;
         out_wr_en_d  = 1'b0;
         exec_taken_d = 1'b0;
         illegal_d    = 1'b0;
      end
   end

   // Flag and late-Z state: the late Z resolves first, a newer executing
   // set_z instruction in the same cycle overrides it
   always_comb begin
      c_flag_d = c_flag_q;
      z_flag_d = z_flag_q;
      state_d  = state_q;
      if ((state_q == ZPEND) && mem_z_valid) begin
         z_flag_d = mem_z;
         state_d  = IDLE;
      end
      if (exec_cap) begin
         if (set_c) begin
            c_flag_d = alu_carry;
         end
         if (set_z) begin
            if (is_load) begin
               state_d = ZPEND;
            end else begin
               z_flag_d = alu_zero;
               state_d  = IDLE;
            end
         end
      end
   end

   // State registers with synchronous reset
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= IDLE;
         out_valid_q  <= 1'b0;
         out_data_q   <= '0;
         out_rd_q     <= '0;
         out_wr_en_q  <= 1'b0;
         exec_taken_q <= 1'b0;
         illegal_q    <= 1'b0;
         c_flag_q     <= 1'b0;
         z_flag_q     <= 1'b0;
      end else begin
         state_q      <= state_d;
         out_valid_q  <= out_valid_d;
         out_data_q   <= out_data_d;
         out_rd_q     <= out_rd_d;
         out_wr_en_q  <= out_wr_en_d;
         exec_taken_q <= exec_taken_d;
         illegal_q    <= illegal_d;
         c_flag_q     <= c_flag_d;
         z_flag_q     <= z_flag_d;
      end
   end

   assign out_valid  = out_valid_q;
   assign out_data   = out_data_q;
   assign out_rd     = out_rd_q;
   assign out_wr_en  = out_wr_en_q;
   assign exec_taken = exec_taken_q;
   assign illegal    = illegal_q;
   assign c_flag     = c_flag_q;
   assign z_flag     = z_flag_q;

endmodule
